// File: rtl/discharge_pulse_scheduler_if.sv
// Command/config inputs, gap-detector flags and drive/status outputs of the EDM pulse scheduler.
interface discharge_pulse_scheduler_if;
    logic        start_cmd;
    logic        stop_cmd;
    logic        single_req;
    logic [15:0] ton_us;
    logic [15:0] toff_us;
    logic        is_breakdown;
    logic        is_short;
    logic        gap_on;
    logic        deion_on;
    logic        busy;
    logic [2:0]  state;
    logic [31:0] pulse_cnt;
    logic [15:0] open_cnt;
    logic [15:0] short_cnt;
    logic        single_done;

    modport master (
        output start_cmd, stop_cmd, single_req, ton_us, toff_us, is_breakdown, is_short,
        input  gap_on, deion_on, busy, state, pulse_cnt, open_cnt, short_cnt, single_done
    );

    modport slave (
        input  start_cmd, stop_cmd, single_req, ton_us, toff_us, is_breakdown, is_short,
        output gap_on, deion_on, busy, state, pulse_cnt, open_cnt, short_cnt, single_done
    );
endinterface

// File: rtl/discharge_pulse_scheduler.sv
// EDM discharge pulse sequencer: gap voltage, breakdown wait, Ton, dead time and Toff deionisation.
// Gate enables are registered from the next state so they drop together with the state change.
module discharge_pulse_scheduler #(
    parameter int CLK_FREQ_MHZ = 50,
    parameter int DEAD_TIME    = 10,
    parameter int MAX_WAIT_US  = 1000
) (
    input  logic                      clk_in,
    input  logic                      sys_rst,
    discharge_pulse_scheduler_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DEAD      = 3'd1,
        WAIT_BD   = 3'd2,
        DISCHARGE = 3'd3,
        DEION     = 3'd4
    } state_t;

    localparam int PW = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
    localparam int DW = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FREQ_MHZ - 1);
    localparam logic [DW-1:0] DEAD_LAST  = DW'(DEAD_TIME - 1);
    localparam logic [15:0]   WAIT_LAST  = 16'(MAX_WAIT_US - 1);

    state_t        state_q, state_d, target_q, target_d;
    logic [PW-1:0] presc_q;
    logic [15:0]   us_q;
    logic [DW-1:0] dead_q;
    logic [15:0]   ton_q, toff_q;
    logic          single_q, single_d, stop_q;
    logic [31:0]   pulse_q;
    logic [15:0]   open_q, short_q;
    logic          clear_cnt, inc_pulse, inc_open, inc_short, finish_single;
    logic          gap_d, deion_d, done_d, gap_q, deion_q, done_q;
    logic          tick, ton_done, toff_done, wait_done, dead_done, stop_pend, entering;

    // A duration of N us ends on the last prescaler cycle of the N-th microsecond.
    assign tick      = (presc_q == PRESC_LAST);
    assign ton_done  = tick && (us_q == ton_q - 16'd1);
    assign toff_done = tick && (us_q == toff_q - 16'd1);
    assign wait_done = tick && (us_q == WAIT_LAST);
    assign dead_done = (dead_q == DEAD_LAST);
    assign stop_pend = stop_q || bus.stop_cmd;
    assign entering  = (state_d != state_q);

    always_ff @(posedge clk_in or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= IDLE;
            target_q <= IDLE;
            gap_q    <= 1'b0;
            deion_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            gap_q    <= gap_d;
            deion_q  <= deion_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        single_d      = single_q;
        clear_cnt     = 1'b0;
        inc_pulse     = 1'b0;
        inc_open      = 1'b0;
        inc_short     = 1'b0;
        finish_single = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.stop_cmd && bus.start_cmd) begin
                    clear_cnt = 1'b1;
                    single_d  = 1'b0;
                    state_d   = DEAD;
                    target_d  = WAIT_BD;
                end else if (!bus.stop_cmd && bus.single_req) begin
                    single_d = 1'b1;
                    state_d  = DEAD;
                    target_d = WAIT_BD;
                end
            end
            DEAD: begin
                if (dead_done) state_d = target_q;
            end
            // No discharge has happened yet, so a stop here skips deionisation.
            WAIT_BD: begin
                if (bus.is_short) begin
                    inc_short = 1'b1;
                    state_d   = DEAD;
                    target_d  = DEION;
                end else if (bus.is_breakdown) begin
                    state_d = DISCHARGE;
                end else if (wait_done) begin
                    inc_open = 1'b1;
                    state_d  = DEAD;
                    target_d = DEION;
                end else if (stop_pend) begin
                    state_d  = DEAD;
                    target_d = IDLE;
                end
            end
            DISCHARGE: begin
                if (ton_done) begin
                    inc_pulse = 1'b1;
                    state_d   = DEAD;
                    target_d  = DEION;
                end else if (bus.is_short) begin
                    inc_short = 1'b1;
                    state_d   = DEAD;
                    target_d  = DEION;
                end
            end
            DEION: begin
                if (toff_done) begin
                    if (stop_pend) begin
                        state_d = IDLE;
                    end else if (single_q) begin
                        state_d       = IDLE;
                        finish_single = 1'b1;
                    end else begin
                        state_d  = DEAD;
                        target_d = WAIT_BD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gap_d   = (state_d == WAIT_BD) || (state_d == DISCHARGE);
        deion_d = (state_d == DEION);
        done_d  = finish_single;
    end

    always_ff @(posedge clk_in or posedge sys_rst) begin
        if (sys_rst) begin
            presc_q  <= '0;
            us_q     <= '0;
            dead_q   <= '0;
            ton_q    <= 16'd1;
            toff_q   <= 16'd1;
            single_q <= 1'b0;
            stop_q   <= 1'b0;
            pulse_q  <= '0;
            open_q   <= '0;
            short_q  <= '0;
        end else begin
            if (entering || state_q == IDLE) begin
                presc_q <= '0;
                us_q    <= '0;
                dead_q  <= '0;
            end else begin
                if (state_q == DEAD) dead_q <= dead_q + DW'(1);
                if (tick) begin
                    presc_q <= '0;
                    us_q    <= us_q + 16'd1;
                end else begin
                    presc_q <= presc_q + PW'(1);
                end
            end

            // Config is sampled once per pulse so mid-pulse edits only affect the next one.
            if (entering && state_d == WAIT_BD) begin
                ton_q  <= (bus.ton_us == 16'd0) ? 16'd1 : bus.ton_us;
                toff_q <= (bus.toff_us == 16'd0) ? 16'd1 : bus.toff_us;
            end

            single_q <= single_d;
            if (state_d == IDLE) stop_q <= 1'b0;
            else if (bus.stop_cmd && state_q != IDLE) stop_q <= 1'b1;

            if (clear_cnt) begin
                pulse_q <= '0;
                open_q  <= '0;
                short_q <= '0;
            end else begin
                if (inc_pulse) pulse_q <= pulse_q + 32'd1;
                if (inc_open)  open_q  <= open_q + 16'd1;
                if (inc_short) short_q <= short_q + 16'd1;
            end
        end
    end

    assign bus.gap_on      = gap_q;
    assign bus.deion_on    = deion_q;
    assign bus.single_done = done_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.state       = state_q;
    assign bus.pulse_cnt   = pulse_q;
    assign bus.open_cnt    = open_q;
    assign bus.short_cnt   = short_q;

endmodule

// File: tb/tb_discharge_pulse_scheduler.sv
// Bench for discharge_pulse_scheduler: command table, timed directed sequences at default parameters,
// and a randomized run of a scaled-down instance against a cycle-countdown reference model.
module tb_discharge_pulse_scheduler;

    localparam int F    = 50;
    localparam int DT   = 10;
    localparam int MW   = 1000;
    localparam int S_F  = 4;
    localparam int S_DT = 3;
    localparam int S_MW = 12;

    logic clk_in  = 1'b0;
    logic sys_rst = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   overlap_cycles = 0;

    discharge_pulse_scheduler_if bus ();
    discharge_pulse_scheduler_if bus_s ();

    discharge_pulse_scheduler #(.CLK_FREQ_MHZ(F), .DEAD_TIME(DT), .MAX_WAIT_US(MW)) dut (
        .clk_in (clk_in),
        .sys_rst(sys_rst),
        .bus    (bus)
    );

    discharge_pulse_scheduler #(.CLK_FREQ_MHZ(S_F), .DEAD_TIME(S_DT), .MAX_WAIT_US(S_MW)) dut_s (
        .clk_in (clk_in),
        .sys_rst(sys_rst),
        .bus    (bus_s)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if ((bus.gap_on && bus.deion_on) || (bus_s.gap_on && bus_s.deion_on)) overlap_cycles++;
    end

    typedef struct {
        string      name;
        logic       start;
        logic       stop;
        logic       single;
        logic [2:0] exp_state;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[7];

    // Reference model state: phase number, cycles left in that phase, and bookkeeping.
    int          m_state, m_rem, m_target, m_ton, m_toff;
    bit          m_single, m_stop, m_done;
    logic [31:0] m_pulse;
    logic [15:0] m_open, m_short;

    task automatic step();
        @(negedge clk_in);
    endtask

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic clear_inputs();
        bus.start_cmd = 0;   bus.stop_cmd = 0;   bus.single_req = 0;
        bus.ton_us = 16'd1;  bus.toff_us = 16'd1;
        bus.is_breakdown = 0; bus.is_short = 0;
        bus_s.start_cmd = 0; bus_s.stop_cmd = 0; bus_s.single_req = 0;
        bus_s.ton_us = 16'd1; bus_s.toff_us = 16'd1;
        bus_s.is_breakdown = 0; bus_s.is_short = 0;
    endtask

    task automatic do_reset();
        #1;
        sys_rst = 1'b1;
        clear_inputs();
        step();
        step();
        #1 sys_rst = 1'b0;
        step();
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return bus.gap_on;
            1:       return bus.deion_on;
            default: return bus.busy;
        endcase
    endfunction

    task automatic run_until(input int sel, input logic level, input int budget, output int n);
        n = 0;
        while (sig(sel) !== level && n < budget) begin
            step();
            n++;
        end
    endtask

    task automatic measure_high(input int sel, input int budget, output int n);
        n = 0;
        while (sig(sel) === 1'b1 && n < budget) begin
            step();
            n++;
        end
    endtask

    task automatic pulse_cmd(input bit start, input bit stop, input bit single);
        bus.start_cmd = start; bus.stop_cmd = stop; bus.single_req = single;
        step();
        bus.start_cmd = 0; bus.stop_cmd = 0; bus.single_req = 0;
    endtask

    task automatic apply_stimulus(input vec_t v);
        do_reset();
        pulse_cmd(v.start, v.stop, v.single);
    endtask

    function automatic int clamp1(input logic [15:0] v);
        return (v == 16'd0) ? 1 : int'(v);
    endfunction

    task automatic m_enter(input int s, input int tgt);
        m_state  = s;
        m_target = tgt;
        case (s)
            1:       m_rem = S_DT;
            2: begin
                m_ton  = clamp1(bus_s.ton_us);
                m_toff = clamp1(bus_s.toff_us);
                m_rem  = S_MW * S_F;
            end
            3:       m_rem = m_ton * S_F;
            4:       m_rem = m_toff * S_F;
            default: m_rem = 0;
        endcase
    endtask

    task automatic m_reset();
        m_state = 0; m_rem = 0; m_target = 0; m_ton = 1; m_toff = 1;
        m_single = 0; m_stop = 0; m_done = 0;
        m_pulse = '0; m_open = '0; m_short = '0;
    endtask

    task automatic m_step();
        int cur;
        bit stop_p;
        cur    = m_state;
        stop_p = m_stop || bus_s.stop_cmd;
        m_done = 0;
        case (cur)
            0: if (!bus_s.stop_cmd) begin
                if (bus_s.start_cmd) begin
                    m_pulse = '0; m_open = '0; m_short = '0; m_single = 0;
                    m_enter(1, 2);
                end else if (bus_s.single_req) begin
                    m_single = 1;
                    m_enter(1, 2);
                end
            end
            1: if (m_rem == 1) m_enter(m_target, m_target); else m_rem--;
            2: if (bus_s.is_short) begin m_short++; m_enter(1, 4); end
               else if (bus_s.is_breakdown) m_enter(3, m_target);
               else if (m_rem == 1) begin m_open++; m_enter(1, 4); end
               else if (stop_p) m_enter(1, 0);
               else m_rem--;
            3: if (m_rem == 1) begin m_pulse++; m_enter(1, 4); end
               else if (bus_s.is_short) begin m_short++; m_enter(1, 4); end
               else m_rem--;
            4: if (m_rem == 1) begin
                   if (stop_p) m_enter(0, 0);
                   else if (m_single) begin m_done = 1; m_enter(0, 0); end
                   else m_enter(1, 2);
               end else m_rem--;
            default: m_enter(0, 0);
        endcase
        if (m_state == 0) m_stop = 0;
        else if (bus_s.stop_cmd && cur != 0) m_stop = 1;
    endtask

    initial begin
        int n;
        int bd_rate;
        logic [74:0] dut_v, exp_v;

        vecs[0] = '{"no command",        0, 0, 0, 3'd0, 1'b0};
        vecs[1] = '{"start",             1, 0, 0, 3'd1, 1'b1};
        vecs[2] = '{"single",            0, 0, 1, 3'd1, 1'b1};
        vecs[3] = '{"start+single",      1, 0, 1, 3'd1, 1'b1};
        vecs[4] = '{"stop+start",        1, 1, 0, 3'd0, 1'b0};
        vecs[5] = '{"stop+single",       0, 1, 1, 3'd0, 1'b0};
        vecs[6] = '{"stop alone",        0, 1, 0, 3'd0, 1'b0};

        clear_inputs();
        do_reset();
        check_output("reset flags", {bus.gap_on, bus.deion_on, bus.busy, bus.single_done, bus.state}, 0);
        check_output("reset counters", {bus.pulse_cnt, bus.open_cnt, bus.short_cnt}, 0);

        for (int i = 0; i < 7; i++) begin
            apply_stimulus(vecs[i]);
            check_output({"cmd ", vecs[i].name},
                         {bus.state, bus.busy, bus.gap_on, bus.deion_on},
                         {vecs[i].exp_state, vecs[i].exp_busy, 2'b00});
        end

        // Single shot with breakdown 20 us after gap voltage is applied.
        do_reset();
        bus.ton_us = 16'd100; bus.toff_us = 16'd50;
        pulse_cmd(0, 0, 1);
        run_until(0, 1'b1, 40, n);
        check_output("t1 dead before gap", n, DT);
        n = 0;
        while (bus.gap_on === 1'b1 && n < 12000) begin
            n++;
            if (n == 20 * F) bus.is_breakdown = 1'b1;
            step();
        end
        bus.is_breakdown = 1'b0;
        check_output("t1 gap_on length", n, 120 * F);
        run_until(1, 1'b1, 40, n);
        check_output("t1 gap to deion", n, DT);
        measure_high(1, 6000, n);
        check_output("t1 deion length", n, 50 * F);
        check_output("t1 done/state", {bus.single_done, bus.state}, {1'b1, 3'd0});
        check_output("t1 pulse_cnt", bus.pulse_cnt, 1);
        step();
        check_output("t1 done one cycle", bus.single_done, 0);

        // Continuous with breakdown always present: WAIT_BD still occupies one cycle.
        do_reset();
        bus.ton_us = 16'd10; bus.toff_us = 16'd5; bus.is_breakdown = 1'b1;
        pulse_cmd(1, 0, 0);
        run_until(0, 1'b1, 40, n);
        check_output("t2 first dead", n, DT);
        for (int p = 0; p < 3; p++) begin
            measure_high(0, 2000, n);
            check_output("t2 gap length", n, 1 + 10 * F);
            run_until(1, 1'b1, 40, n);
            check_output("t2 dead gap->deion", n, DT);
            measure_high(1, 1000, n);
            check_output("t2 deion length", n, 5 * F);
            run_until(0, 1'b1, 40, n);
            check_output("t2 dead deion->gap", n, DT);
        end
        check_output("t2 pulse_cnt after 3", bus.pulse_cnt, 3);
        repeat (100) step();
        pulse_cmd(0, 1, 0);
        measure_high(0, 2000, n);
        check_output("t2 stopped pulse completes", n + 101, 1 + 10 * F);
        run_until(1, 1'b1, 40, n);
        check_output("t2 stop dead", n, DT);
        measure_high(1, 1000, n);
        check_output("t2 stop deion", n, 5 * F);
        check_output("t2 idle after stop", {bus.state, bus.busy, bus.single_done}, 0);
        check_output("t2 pulse_cnt final", bus.pulse_cnt, 4);
        bus.is_breakdown = 1'b0;

        // Open circuit: no breakdown at all.
        do_reset();
        bus.ton_us = 16'd5; bus.toff_us = 16'd1;
        pulse_cmd(0, 0, 1);
        run_until(0, 1'b1, 40, n);
        measure_high(0, 60000, n);
        check_output("t3 open gap length", n, MW * F);
        check_output("t3 open_cnt", bus.open_cnt, 1);
        run_until(1, 1'b1, 40, n);
        check_output("t3 dead before deion", n, DT);
        measure_high(1, 200, n);
        check_output("t3 deion length", n, F);
        check_output("t3 idle/done/pulse", {bus.state, bus.single_done, bus.pulse_cnt}, {3'd0, 1'b1, 32'd0});

        // Short 100 cycles into DISCHARGE.
        do_reset();
        bus.ton_us = 16'd100; bus.toff_us = 16'd1; bus.is_breakdown = 1'b1;
        pulse_cmd(0, 0, 1);
        run_until(0, 1'b1, 40, n);
        step();
        check_output("t4 in discharge", bus.state, 3);
        repeat (99) step();
        bus.is_short = 1'b1;
        step();
        bus.is_short = 1'b0;
        bus.is_breakdown = 1'b0;
        check_output("t4 gap drops", {bus.gap_on, bus.state}, {1'b0, 3'd1});
        check_output("t4 counters", {bus.short_cnt, bus.pulse_cnt}, {16'd1, 32'd0});
        run_until(1, 1'b1, 40, n);
        check_output("t4 deion after dead", n, DT);

        // Ton edited mid-pulse only takes effect on the following pulse.
        do_reset();
        bus.ton_us = 16'd100; bus.toff_us = 16'd1; bus.is_breakdown = 1'b1;
        pulse_cmd(1, 0, 0);
        run_until(0, 1'b1, 40, n);
        step();
        step();
        bus.ton_us = 16'd20;
        measure_high(0, 12000, n);
        check_output("t5 current pulse", n + 2, 1 + 100 * F);
        run_until(0, 1'b1, 200, n);
        check_output("t5 gap off interval", n, 2 * DT + F);
        measure_high(0, 3000, n);
        check_output("t5 next pulse", n, 1 + 20 * F);
        pulse_cmd(0, 1, 0);
        run_until(2, 1'b0, 400, n);
        check_output("t5 stop via deion", n + 1, DT + F);
        bus.is_breakdown = 1'b0;

        // Asynchronous reset in the middle of a discharge.
        do_reset();
        bus.ton_us = 16'd1; bus.toff_us = 16'd1; bus.is_breakdown = 1'b1;
        pulse_cmd(1, 0, 0);
        run_until(0, 1'b1, 40, n);
        measure_high(0, 200, n);
        bus.ton_us = 16'd100;
        run_until(0, 1'b1, 200, n);
        repeat (10) step();
        check_output("t6 pre-reset", {bus.state, bus.pulse_cnt}, {3'd3, 32'd1});
        #1 sys_rst = 1'b1;
        #1;
        check_output("t6 async gates", {bus.gap_on, bus.deion_on, bus.busy, bus.state}, 0);
        check_output("t6 async counters", {bus.pulse_cnt, bus.open_cnt, bus.short_cnt}, 0);
        step();
        step();
        #1 sys_rst = 1'b0;
        bus.ton_us = 16'd1;
        step();
        pulse_cmd(1, 0, 1);
        run_until(0, 1'b1, 40, n);
        measure_high(0, 200, n);
        check_output("t6 gap length", n, 1 + F);
        run_until(1, 1'b1, 40, n);
        measure_high(1, 200, n);
        check_output("t6 continuous after deion", {bus.state, bus.single_done, bus.busy}, {3'd1, 1'b0, 1'b1});
        pulse_cmd(0, 1, 0);
        run_until(2, 1'b0, 400, n);
        check_output("t6 stopped", bus.state, 0);
        bus.is_breakdown = 1'b0;

        // Randomized run of the scaled-down instance against the reference model.
        do_reset();
        m_reset();
        bd_rate = 3;
        for (int c = 0; c < 4000; c++) begin
            dut_v = {bus_s.state, bus_s.gap_on, bus_s.deion_on, bus_s.busy, bus_s.single_done,
                     bus_s.pulse_cnt, bus_s.open_cnt, bus_s.short_cnt};
            exp_v = {3'(m_state), (m_state == 2 || m_state == 3), (m_state == 4), (m_state != 0), m_done,
                     m_pulse, m_open, m_short};
            tests_run++;
            if (dut_v !== exp_v) begin
                tests_failed++;
                $display("[TB] FAIL random cycle %0d: dut %h, model %h", c, dut_v, exp_v);
                break;
            end
            if ($urandom_range(99) == 0) bd_rate = ($urandom_range(1) == 0) ? 3 : 200;
            bus_s.start_cmd    = ($urandom_range(59) == 0);
            bus_s.single_req   = ($urandom_range(39) == 0);
            bus_s.stop_cmd     = ($urandom_range(99) == 0);
            bus_s.is_breakdown = ($urandom_range(bd_rate) == 0);
            bus_s.is_short     = ($urandom_range(49) == 0);
            if ($urandom_range(15) == 0) bus_s.ton_us  = 16'($urandom_range(3));
            if ($urandom_range(15) == 0) bus_s.toff_us = 16'($urandom_range(3));
            m_step();
            step();
        end

        check_output("no gap/deion overlap", overlap_cycles, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
